// File: rtl/meter_pkg.sv
// Shared types, state encoding, default parameters and saturating helpers for the VU meter controller.
package meter_pkg;
  localparam int SAMPLE_W          = 8;
  localparam int DEF_DECAY_STEP    = 4;
  localparam int DEF_HOLD_TICKS    = 32;
  localparam int DEF_TIMEOUT_TICKS = 255;

  typedef logic [SAMPLE_W-1:0] sample_t;
  typedef logic [1:0]          state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_STALE = 2'd2;

  function automatic sample_t sat_sub(input sample_t a, input sample_t b);
    return (a > b) ? sample_t'(a - b) : '0;
  endfunction

  function automatic sample_t max_s(input sample_t a, input sample_t b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/meter_if.sv
// Sample/strobe inputs and display outputs of the meter controller, bundled for port hookup.
interface meter_if;
  import meter_pkg::*;

  logic    enable;
  sample_t data_in;
  logic    load;
  logic    error;
  logic    decay_tick;
  sample_t level;
  sample_t peak;
  logic    stale;
  sample_t err_count;

  modport master (
    output enable, data_in, load, error, decay_tick,
    input  level, peak, stale, err_count
  );

  modport slave (
    input  enable, data_in, load, error, decay_tick,
    output level, peak, stale, err_count
  );
endinterface

// File: rtl/meter_hold_timer.sv
// Loadable down-counter with tick enable and zero flag; times the peak-hold interval.
module meter_hold_timer
  import meter_pkg::*;
(
  input  logic    clock,
  input  logic    reset,
  input  logic    load,
  input  sample_t load_val,
  input  logic    tick,
  output logic    zero
);
  sample_t count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (tick && count != '0)
      count <= count - 8'd1;
  end

  assign zero = (count == '0);
endmodule

// File: rtl/meter_ctrl.sv
// VU meter level/peak controller: instant attack, timed release, peak hold and stale-link watchdog.
// Peak-hold marker is built only when PEAK_HOLD_EN is defined; otherwise peak mirrors level.
//
// state    | meaning
// ST_IDLE  | no valid byte since reset, never times out
// ST_RUN   | receiving; timeout counter runs on decay_tick
// ST_STALE | link timed out; release floor forced to 0
module meter_ctrl
  import meter_pkg::*;
#(
  parameter int DECAY_STEP    = DEF_DECAY_STEP,
  parameter int HOLD_TICKS    = DEF_HOLD_TICKS,
  parameter int TIMEOUT_TICKS = DEF_TIMEOUT_TICKS
) (
  input logic   clock,
  input logic   reset,
  meter_if.slave bus
);
  localparam sample_t DSTEP = 8'(DECAY_STEP);
  localparam sample_t TMAX  = 8'(TIMEOUT_TICKS);

  state_t  state, state_next;
  sample_t level, level_next, s, floor_v, tcnt, tcnt_next, err_count;
  logic    stale_q;
  logic    valid, bad, tick;

  assign valid = bus.enable & bus.load & ~bus.error;
  assign bad   = bus.enable & bus.load &  bus.error;
  assign tick  = bus.enable & bus.decay_tick;

  // A coincident valid byte becomes the release floor immediately.
  assign floor_v = valid ? bus.data_in : ((state == ST_STALE) ? '0 : s);

  always_comb begin
    level_next = level;
    if (valid && bus.data_in > level)
      level_next = bus.data_in;
    else if (tick)
      level_next = max_s(sat_sub(level, DSTEP), floor_v);
  end

  always_comb begin
    tcnt_next = tcnt;
    if (valid)
      tcnt_next = '0;
    else if (tick && state == ST_RUN && tcnt != TMAX)
      tcnt_next = tcnt + 8'd1;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (valid) state_next = ST_RUN;
      ST_RUN:   if (!valid && tcnt_next == TMAX) state_next = ST_STALE;
      ST_STALE: if (valid) state_next = ST_RUN;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      stale_q   <= 1'b0;
      level     <= '0;
      s         <= '0;
      tcnt      <= '0;
      err_count <= '0;
    end else if (bus.enable) begin
      state   <= state_next;
      stale_q <= (state_next == ST_STALE);
      level   <= level_next;
      tcnt    <= tcnt_next;
      if (valid)
        s <= bus.data_in;
      else if (state == ST_STALE)
        s <= '0;
      if (bad && err_count != 8'hFF)
        err_count <= err_count + 8'd1;
    end
  end

`ifdef PEAK_HOLD_EN
  sample_t peak;
  logic    peak_load, hold_zero;

  assign peak_load = valid && (bus.data_in >= peak);

  meter_hold_timer u_hold (
    .clock    (clock),
    .reset    (reset),
    .load     (peak_load),
    .load_val (8'(HOLD_TICKS)),
    .tick     (tick),
    .zero     (hold_zero)
  );

  // Decay floor is the new level so the marker never sits below the bar.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      peak <= '0;
    else if (peak_load)
      peak <= bus.data_in;
    else if (tick && hold_zero)
      peak <= max_s(sat_sub(peak, DSTEP), level_next);
  end

  assign bus.peak = peak;
`else
  logic hold_unused;
  assign hold_unused = |8'(HOLD_TICKS);
  assign bus.peak    = level;
`endif

  assign bus.level     = level;
  assign bus.stale     = stale_q;
  assign bus.err_count = err_count;
endmodule

// File: tb/tb_meter_ctrl.sv
// Self-checking bench for meter_ctrl: directed scenarios plus randomized traffic against a rule-level model.
module tb_meter_ctrl;
  localparam int STEP    = 4;
  localparam int TIMEOUT = 255;
`ifdef PEAK_HOLD_EN
  localparam int HOLD    = 32;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_cmp  = 0;
  int   n_fail = 0;

  meter_if bus ();

  meter_ctrl dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Reference model: quantities described by the behavioural rules.
  int m_lvl, m_pk, m_s, m_err, m_quiet;
  bit m_seen;
`ifdef PEAK_HOLD_EN
  int m_hold;
`endif

  task automatic model_reset();
    m_lvl = 0; m_pk = 0; m_s = 0; m_err = 0; m_quiet = 0; m_seen = 0;
`ifdef PEAK_HOLD_EN
    m_hold = 0;
`endif
  endtask

  function automatic bit model_stale();
    return m_seen && (m_quiet >= TIMEOUT);
  endfunction

  task automatic model_cycle(input bit en, input bit ld, input bit er, input int d, input bit tk);
    bit valid, stale_b;
    int floor_v, new_lvl, dec;
    if (!en) return;
    valid = ld && !er;
    if (ld && er && m_err < 255) m_err++;
    stale_b = model_stale();
    floor_v = valid ? d : (stale_b ? 0 : m_s);
    new_lvl = m_lvl;
    if (valid && d > m_lvl) new_lvl = d;
    else if (tk) begin
      dec = m_lvl - STEP;
      if (dec < 0) dec = 0;
      new_lvl = (dec > floor_v) ? dec : floor_v;
    end
`ifdef PEAK_HOLD_EN
    if (valid && d >= m_pk) begin
      m_pk = d; m_hold = HOLD;
    end else if (tk) begin
      if (m_hold > 0) m_hold--;
      else begin
        dec = m_pk - STEP;
        if (dec < 0) dec = 0;
        m_pk = (dec > new_lvl) ? dec : new_lvl;
      end
    end
`else
    m_pk = new_lvl;
`endif
    m_lvl = new_lvl;
    if (valid) begin
      m_s = d; m_seen = 1; m_quiet = 0;
    end else begin
      if (stale_b) m_s = 0;
      if (tk && m_seen && m_quiet < TIMEOUT) m_quiet++;
    end
  endtask

  task automatic step(input bit en, input bit ld, input bit er, input int d, input bit tk);
    bus.enable = en; bus.load = ld; bus.error = er; bus.data_in = 8'(d); bus.decay_tick = tk;
    @(posedge clock); #1;
    model_cycle(en, ld, er, d, tk);
    bus.enable = 1'b1; bus.load = 1'b0; bus.error = 1'b0; bus.decay_tick = 1'b0;
  endtask

  task automatic test_reset();
    bus.enable = 1'b1; bus.load = 1'b0; bus.error = 1'b0; bus.data_in = '0; bus.decay_tick = 1'b0;
    reset = 1'b0;
    model_reset();
    #23;
    n_cmp += 4;
    if (bus.level !== 8'h00) begin n_fail++; $display("FAIL reset_level got %h want 00", bus.level); end
    if (bus.peak !== 8'h00) begin n_fail++; $display("FAIL reset_peak got %h want 00", bus.peak); end
    if (bus.stale !== 1'b0) begin n_fail++; $display("FAIL reset_stale got %b want 0", bus.stale); end
    if (bus.err_count !== 8'h00) begin n_fail++; $display("FAIL reset_err got %h want 00", bus.err_count); end
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_attack();
    step(1, 1, 0, 8'h80, 0);
    n_cmp += 3;
    if (bus.level !== 8'h80) begin n_fail++; $display("FAIL attack_level got %h want 80", bus.level); end
    if (bus.peak !== 8'h80) begin n_fail++; $display("FAIL attack_peak got %h want 80", bus.peak); end
    if (bus.stale !== 1'b0) begin n_fail++; $display("FAIL attack_stale got %b want 0", bus.stale); end
  endtask

  task automatic test_release();
    step(1, 1, 0, 8'h10, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 1);
    n_cmp++;
    if (bus.level !== 8'h6C) begin n_fail++; $display("FAIL release_5 got %h want 6c", bus.level); end
    for (int i = 0; i < 40; i++) step(1, 0, 0, 0, 1);
    n_cmp += 2;
    if (bus.level !== 8'h10) begin n_fail++; $display("FAIL release_floor got %h want 10", bus.level); end
    if (bus.peak !== 8'(m_pk)) begin n_fail++; $display("FAIL release_peak got %h want %h", bus.peak, 8'(m_pk)); end
  endtask

  task automatic test_peak_hold();
    step(1, 1, 0, 8'hF0, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 8'h20, 0);
    for (int i = 0; i < 32; i++) begin
      step(1, 0, 0, 0, 1);
`ifndef PEAK_HOLD_EN
      n_cmp++;
      if (bus.peak !== bus.level || bus.peak !== 8'(m_lvl)) begin
        n_fail++; $display("FAIL peak_tracks got %h want %h", bus.peak, 8'(m_lvl));
      end
`endif
    end
`ifdef PEAK_HOLD_EN
    n_cmp++;
    if (bus.peak !== 8'hF0) begin n_fail++; $display("FAIL peak_hold got %h want f0", bus.peak); end
`endif
    step(1, 0, 0, 0, 1);
    n_cmp += 2;
    if (bus.level !== 8'h6C) begin n_fail++; $display("FAIL hold_level got %h want 6c", bus.level); end
`ifdef PEAK_HOLD_EN
    if (bus.peak !== 8'hEC) begin n_fail++; $display("FAIL peak_decay got %h want ec", bus.peak); end
`else
    if (bus.peak !== 8'h6C) begin n_fail++; $display("FAIL peak_decay got %h want 6c", bus.peak); end
`endif
  endtask

  task automatic test_errors_stale();
    logic [7:0] lvl0, pk0;
    step(1, 1, 0, 8'h90, 0);
    for (int i = 0; i < 100; i++) step(1, 0, 0, 0, 1);
    lvl0 = bus.level; pk0 = bus.peak;
    for (int i = 0; i < 300; i++) step(1, 1, 1, $urandom_range(0, 255), 0);
    n_cmp += 4;
    if (bus.err_count !== 8'hFF) begin n_fail++; $display("FAIL err_sat got %h want ff", bus.err_count); end
    if (bus.level !== 8'h90) begin n_fail++; $display("FAIL err_level got %h want 90", bus.level); end
    if (bus.level !== lvl0 || bus.peak !== pk0) begin
      n_fail++; $display("FAIL err_hold got %h/%h want %h/%h", bus.level, bus.peak, lvl0, pk0);
    end
    if (bus.peak !== 8'(m_pk)) begin n_fail++; $display("FAIL err_peak got %h want %h", bus.peak, 8'(m_pk)); end
    for (int i = 0; i < 154; i++) step(1, 0, 0, 0, 1);
    n_cmp++;
    if (bus.stale !== 1'b0) begin n_fail++; $display("FAIL stale_early got %b want 0", bus.stale); end
    step(1, 0, 0, 0, 1);
    n_cmp++;
    if (bus.stale !== 1'b1) begin n_fail++; $display("FAIL stale_set got %b want 1", bus.stale); end
    for (int i = 0; i < 40; i++) step(1, 0, 0, 0, 1);
    n_cmp += 2;
    if (bus.level !== 8'h00) begin n_fail++; $display("FAIL stale_release got %h want 00", bus.level); end
    if (bus.peak !== 8'(m_pk)) begin n_fail++; $display("FAIL stale_peak got %h want %h", bus.peak, 8'(m_pk)); end
    step(1, 1, 0, 8'h40, 0);
    n_cmp += 2;
    if (bus.stale !== 1'b0) begin n_fail++; $display("FAIL stale_clear got %b want 0", bus.stale); end
    if (bus.level !== 8'h40) begin n_fail++; $display("FAIL stale_reload got %h want 40", bus.level); end
  endtask

  task automatic test_coincident();
    step(1, 1, 0, 8'h30, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 1);
    n_cmp++;
    if (bus.level !== 8'h30) begin n_fail++; $display("FAIL coin_pre got %h want 30", bus.level); end
    step(1, 1, 0, 8'h50, 1);
    n_cmp += 2;
    if (bus.level !== 8'h50) begin n_fail++; $display("FAIL coin_attack got %h want 50", bus.level); end
    if (bus.peak !== 8'(m_pk)) begin n_fail++; $display("FAIL coin_peak got %h want %h", bus.peak, 8'(m_pk)); end
    step(1, 1, 0, 8'h20, 1);
    n_cmp++;
    if (bus.level !== 8'h4C) begin n_fail++; $display("FAIL coin_release got %h want 4c", bus.level); end
  endtask

  task automatic test_random();
    int load_pct;
    for (int ph = 0; ph < 2; ph++) begin
      load_pct = (ph == 0) ? 25 : 1;
      for (int i = 0; i < 1500; i++) begin
        step($urandom_range(0, 99) < 90,
             $urandom_range(0, 99) < load_pct,
             $urandom_range(0, 99) < 15,
             $urandom_range(0, 255),
             $urandom_range(0, 99) < 50);
        n_cmp++;
        if (bus.level !== 8'(m_lvl) || bus.peak !== 8'(m_pk) ||
            bus.stale !== model_stale() || bus.err_count !== 8'(m_err)) begin
          n_fail++;
          $display("FAIL random cyc %0d got l=%h p=%h s=%b e=%h want l=%h p=%h s=%b e=%h", i,
                   bus.level, bus.peak, bus.stale, bus.err_count,
                   8'(m_lvl), 8'(m_pk), model_stale(), 8'(m_err));
        end
      end
    end
  endtask

  task automatic test_async_reset();
    step(1, 1, 0, 8'hC0, 0);
    step(1, 0, 0, 0, 1);
    step(1, 1, 0, 8'h05, 0);
    step(1, 0, 0, 0, 1);
    @(posedge clock); #3;
    reset = 1'b0;
    #1;
    model_reset();
    n_cmp += 4;
    if (bus.level !== 8'h00) begin n_fail++; $display("FAIL arst_level got %h want 00", bus.level); end
    if (bus.peak !== 8'h00) begin n_fail++; $display("FAIL arst_peak got %h want 00", bus.peak); end
    if (bus.stale !== 1'b0) begin n_fail++; $display("FAIL arst_stale got %b want 0", bus.stale); end
    if (bus.err_count !== 8'h00) begin n_fail++; $display("FAIL arst_err got %h want 00", bus.err_count); end
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;
    step(1, 1, 0, 8'h22, 0);
    n_cmp++;
    if (bus.level !== 8'h22) begin n_fail++; $display("FAIL arst_recover got %h want 22", bus.level); end
  endtask

  initial begin
    test_reset();
    test_attack();
    test_release();
    test_peak_hold();
    test_errors_stale();
    test_coincident();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached, compared %0d", n_cmp);
    $fatal(1, "time limit");
  end
endmodule

// File: doc/meter_ctrl.md
Name: meter_ctrl

Overview:
Level/peak controller for the VU meter. Sits between the UART receive path (byte + load/error strobes) and the VGA bar renderer. Turns raw received sample bytes into a displayed bar level with instant attack and timed release, plus a peak-hold marker and a stale-link watchdog. Sequences all updates on one clock using a tick strobe from the clock-generation logic.

Parameters:
DECAY_STEP, 4, amount subtracted from level/peak per decay_tick during release
HOLD_TICKS, 32, decay_ticks the peak marker holds before it starts decaying
TIMEOUT_TICKS, 255, decay_ticks with no valid byte before entering STALE (8-bit counter, max 255)

Ports:
clock  input  1  block clock (same domain as the uart load/error strobes)
reset  input  1  asynchronous, active-low reset
enable  input  1  when 0, all state frozen; strobes ignored
data_in  input  8  received sample byte; qualified by load
load  input  1  1-cycle strobe, data_in valid
error  input  1  1-cycle strobe coincident with load; frame bad
decay_tick  input  1  1-cycle release-timebase strobe
level  output  8  displayed bar level
peak  output  8  peak-hold marker position
stale  output  1  high while in STALE state
err_count  output  8  saturating count of rejected frames

Behaviour:
- Reset (reset=0, async): level=0, peak=0, stale=0, err_count=0, hold counter=0, timeout counter=0, state=IDLE.
- FSM states: IDLE (no valid byte since reset), RUN, STALE.
  IDLE -> RUN on the first valid byte. RUN -> STALE when the timeout counter reaches TIMEOUT_TICKS. STALE -> RUN on a valid byte. IDLE never times out.
- Valid byte = load=1 and error=0 and enable=1. Sample register s <= data_in.
- load=1 with error=1: byte discarded, err_count += 1 (saturates at 255), no other state changes.
- Level update has 1-cycle latency after a valid load:
  - Attack: if data_in > level, then level <= data_in.
  - Release: on decay_tick, level <= max(level - DECAY_STEP, s). The subtraction saturates at 0.
  - In STALE, s is forced to 0, so level releases toward 0.
- Peak update, evaluated in the same cycle as the level update:
  - data_in >= peak on a valid load: peak <= data_in, hold counter <= HOLD_TICKS.
  - Otherwise on decay_tick: if hold counter != 0, decrement it; else peak <= max(peak - DECAY_STEP, level_next). peak never drops below level.
- Timeout counter:
  - Cleared on every valid byte.
  - Incremented on decay_tick in RUN, saturating at TIMEOUT_TICKS.
  - Error frames do not clear it.
- Simultaneous valid load and decay_tick:
  - Attack takes priority when data_in > level. Otherwise release is applied with floor = new data_in.
  - Peak: a load with data_in >= peak takes priority over hold/decay.
  - The timeout counter is cleared, not incremented.
- enable=0: all registers hold; strobes are lost (not queued).
- All arithmetic is unsigned 8-bit with saturation, so no wrap-around anywhere.
- stale is registered: asserted the cycle after entering STALE, deasserted the cycle after the valid byte that leaves it.

Optional Feature:
PEAK_HOLD_EN
- Defined: peak-hold logic as above.
- Undefined: the hold counter and peak register are removed; peak is a continuous copy of level (same cycle); HOLD_TICKS is unused.

Decomposition:
- Package meter_pkg holds:
  - FSM state enum (IDLE, RUN, STALE).
  - Sample width constant (8).
  - Saturating-subtract and max helper functions.
  - Default DECAY_STEP/HOLD_TICKS/TIMEOUT_TICKS constants.
- One natural sub-module: meter_hold_timer, a loadable down-counter with tick enable and zero flag. It serves as the peak hold counter; it is instanced only under PEAK_HOLD_EN.

Test Plan:
- Reset then valid load 0x80 -> level=0x80 and peak=0x80 one cycle later, stale=0, state RUN.
- level=0x80, s=0x10, 5 decay_ticks (DECAY_STEP=4) -> level=0x6C; continuing, level floors at 0x10, never below.
- Load 0xF0 then loads of 0x20, then 32 ticks -> peak stays 0xF0 (PEAK_HOLD_EN); tick 33 -> peak=0xEC; without the macro, peak tracks level every cycle.
- Load with error=1, 300 times -> err_count=0xFF saturated, level/peak unchanged, timeout counter not cleared.
- No valid load for 255 ticks after RUN -> stale=1 and level releases to 0; next valid load 0x40 -> stale=0, level=0x40.
- Valid load 0x50 coincident with decay_tick while level=0x30 -> level=0x50 (attack wins); async reset asserted mid-release -> all outputs 0 immediately.
